// File: rtl/wall_map_pkg.sv
// wall_map_pkg: shared constants and types for the wall bitmap block.
//   MAP_W/MAP_H       play-field grid size (status bar rows excluded)
//   HIT_FIFO_DEPTH    pending wall-clear entries (power of 2)
//   GAME_*            game FSM state encoding seen on i_state
//   grid_coord_t      6-bit grid coordinate
//   hit_entry_t       one queued wall-clear {x, y}
//   map_state_t       wall_map FSM states
package wall_map_pkg;

  localparam int MAP_W          = 64;
  localparam int MAP_H          = 44;
  localparam int HIT_FIFO_DEPTH = 4;
  localparam int HIT_PTR_W      = $clog2(HIT_FIFO_DEPTH);
  localparam int HIT_CNT_W      = HIT_PTR_W + 1;

  localparam logic [1:0] GAME_START = 2'b00;
  localparam logic [1:0] GAME_PLAY  = 2'b01;
  localparam logic [1:0] GAME_END   = 2'b10;

  typedef logic [5:0] grid_coord_t;

  typedef struct packed {
    grid_coord_t x;
    grid_coord_t y;
  } hit_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } map_state_t;

  // Coordinate-width versions of the grid limits so compares stay 6-bit.
  localparam grid_coord_t ROW_LIMIT = grid_coord_t'(MAP_H);
  localparam grid_coord_t ROW_LAST  = grid_coord_t'(MAP_H - 1);
  localparam grid_coord_t COL_LAST  = grid_coord_t'(MAP_W - 1);

  localparam logic [HIT_CNT_W-1:0] HIT_CNT_FULL = HIT_CNT_W'(HIT_FIFO_DEPTH);

endpackage

// File: rtl/wall_map_if.sv
// wall_map_if: groups every non-clock/reset signal of wall_map.
//   master modport: driver side (game FSM, display, tank, shell units)
//   slave modport : wall_map side
//   display : i_vga_buzy, i_vga_x, i_vga_y -> o_vga_is_wall
//   query   : i_query_valid, i_query_x, i_query_y -> o_query_valid, o_query_is_wall
//   hit     : i_hit_valid, i_hit_x, i_hit_y -> o_hit_full
//   status  : i_state -> o_ready
interface wall_map_if import wall_map_pkg::*; ();

  logic [1:0]  i_state;
  logic        i_vga_buzy;
  grid_coord_t i_vga_x;
  grid_coord_t i_vga_y;
  logic        o_vga_is_wall;
  logic        i_query_valid;
  grid_coord_t i_query_x;
  grid_coord_t i_query_y;
  logic        o_query_valid;
  logic        o_query_is_wall;
  logic        i_hit_valid;
  grid_coord_t i_hit_x;
  grid_coord_t i_hit_y;
  logic        o_hit_full;
  logic        o_ready;

  modport master (
    output i_state, i_vga_buzy, i_vga_x, i_vga_y,
    output i_query_valid, i_query_x, i_query_y,
    output i_hit_valid, i_hit_x, i_hit_y,
    input  o_vga_is_wall, o_query_valid, o_query_is_wall, o_hit_full, o_ready
  );

  modport slave (
    input  i_state, i_vga_buzy, i_vga_x, i_vga_y,
    input  i_query_valid, i_query_x, i_query_y,
    input  i_hit_valid, i_hit_x, i_hit_y,
    output o_vga_is_wall, o_query_valid, o_query_is_wall, o_hit_full, o_ready
  );

endinterface

// File: rtl/wall_map_rom.sv
// wall_map_rom: combinational initial wall layout, one row per lookup.
//   row_i     : grid row (0..MAP_H-1; rows beyond the field return clear)
//   pattern_o : MAP_W-bit row, bit [x] = 1 means wall
// Layout: solid border ring plus four 4x4 cover blocks at
// rows 10-13 / 30-33, columns 20-23 / 40-43.
module wall_map_rom
  import wall_map_pkg::*;
(
  input  grid_coord_t      row_i,
  output logic [MAP_W-1:0] pattern_o
);

  logic cover_row;

  assign cover_row = ((row_i >= 6'd10) && (row_i <= 6'd13)) ||
                     ((row_i >= 6'd30) && (row_i <= 6'd33));

  always_comb begin
    pattern_o = '0;
    if ((row_i == '0) || (row_i == ROW_LAST)) begin
      pattern_o = '1;
    end else if (row_i < ROW_LIMIT) begin
      pattern_o[0]       = 1'b1;
      pattern_o[MAP_W-1] = 1'b1;
      if (cover_row) begin
        pattern_o[23:20] = '1;
        pattern_o[43:40] = '1;
      end
    end
  end

endmodule

// File: rtl/wall_map.sv
// wall_map: destructible wall bitmap for the 64x44 play field.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wall_map_if.slave (display read, collision query,
//                wall-clear hit FIFO, game state in / ready out)
// A 00/10 -> 01 edge on i_state (re)loads the map from wall_map_rom, one
// row per cycle. Wall clears are queued and only committed while the
// display is in vertical blank (i_vga_buzy == 0) so a frame never tears.
// Build option: define WALL_MAP_SOLID_BORDER_EN to make the border ring
// indestructible (clears aimed at it are drained and dropped).
module wall_map
  import wall_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  wall_map_if.slave   bus
);

  map_state_t              state_q, state_d;
  logic [1:0]              prev_state_q;
  grid_coord_t             row_q, row_d;
  logic [MAP_W-1:0]        map_q [MAP_H];
  logic [MAP_W-1:0]        rom_row;

  hit_entry_t              fifo_q [HIT_FIFO_DEPTH];
  logic [HIT_PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [HIT_CNT_W-1:0]    cnt_q;
  hit_entry_t              pop_entry;

  logic start_edge, flush, load_wr, hit_full, push, pop, clr_en, border_hit;
  logic vga_rd, query_rd;
  logic vga_is_wall_q, query_valid_q, query_is_wall_q, ready_q;

  wall_map_rom u_rom (
    .row_i     (row_q),
    .pattern_o (rom_row)
  );

  assign start_edge = (prev_state_q != GAME_PLAY) && (bus.i_state == GAME_PLAY);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a new play edge restarts the load from any state
  always_comb begin
    state_d = state_q;
    if (start_edge) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_LOAD:  if (row_q == ROW_LAST) state_d = ST_READY;
        ST_READY: if (bus.i_state != GAME_PLAY) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs / datapath controls
  always_comb begin
    flush   = start_edge;
    load_wr = (state_q == ST_LOAD) && !start_edge;
    row_d   = row_q;
    if (flush) begin
      row_d = '0;
    end else if (load_wr) begin
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      prev_state_q <= GAME_START;
    end else begin
      row_q        <= row_d;
      prev_state_q <= bus.i_state;
    end
  end

  // Hit FIFO. Full is judged on the registered count, so a pop in the same
  // cycle does not open a slot for a push.
  assign hit_full  = (cnt_q == HIT_CNT_FULL);
  assign push      = bus.i_hit_valid && !hit_full && (state_q == ST_READY) && !flush;
  assign pop       = (state_q == ST_READY) && !bus.i_vga_buzy && (cnt_q != '0) && !flush;
  assign pop_entry = fifo_q[rd_ptr_q];

`ifdef WALL_MAP_SOLID_BORDER_EN
  assign border_hit = (pop_entry.x == '0) || (pop_entry.x == COL_LAST) ||
                      (pop_entry.y == '0) || (pop_entry.y == ROW_LAST);
`else
  assign border_hit = 1'b0;
`endif

  assign clr_en = pop && (pop_entry.y < ROW_LIMIT) && !border_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < HIT_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{x: bus.i_hit_x, y: bus.i_hit_y};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Map storage: load rows only in LOAD, clears only in READY, so the two
  // writers never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAP_H; r++) map_q[r] <= '0;
    end else if (load_wr) begin
      map_q[row_q] <= rom_row;
    end else if (clr_en) begin
      map_q[pop_entry.y][pop_entry.x] <= 1'b0;
    end
  end

  // Reads see the pre-write value of map_q, so a same-cycle clear is not
  // visible until the next read.
  assign vga_rd   = (bus.i_vga_y < ROW_LIMIT) ? map_q[bus.i_vga_y][bus.i_vga_x] : 1'b0;
  assign query_rd = (state_q != ST_READY) || (bus.i_query_y >= ROW_LIMIT) ||
                    map_q[bus.i_query_y][bus.i_query_x];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_is_wall_q   <= 1'b0;
      query_valid_q   <= 1'b0;
      query_is_wall_q <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      vga_is_wall_q   <= vga_rd;
      query_valid_q   <= bus.i_query_valid;
      query_is_wall_q <= query_rd;
      ready_q         <= (state_q == ST_READY);
    end
  end

  assign bus.o_vga_is_wall   = vga_is_wall_q;
  assign bus.o_query_valid   = query_valid_q;
  assign bus.o_query_is_wall = query_is_wall_q;
  assign bus.o_hit_full      = hit_full;
  assign bus.o_ready         = ready_q;

endmodule

// File: tb/tb_wall_map.sv
// tb_wall_map: directed-vector bench for wall_map with hand-computed
// expectations from the ROM layout (border ring, cover blocks at rows
// 10-13/30-33, columns 20-23/40-43).
module tb_wall_map;
  import wall_map_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  wall_map_if bus ();

  wall_map dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int x, input int y, input logic exp, input string tag);
    bus.i_query_valid = 1'b1;
    bus.i_query_x     = 6'(x);
    bus.i_query_y     = 6'(y);
    tick();
    check_eq({tag, "_vld"}, 32'(bus.o_query_valid), 32'd1);
    check_eq(tag, 32'(bus.o_query_is_wall), 32'(exp));
    bus.i_query_valid = 1'b0;
  endtask

  task automatic vga(input int x, input int y, input logic exp, input string tag);
    bus.i_vga_x = 6'(x);
    bus.i_vga_y = 6'(y);
    tick();
    check_eq(tag, 32'(bus.o_vga_is_wall), 32'(exp));
  endtask

  task automatic push_hit(input int x, input int y);
    bus.i_hit_valid = 1'b1;
    bus.i_hit_x     = 6'(x);
    bus.i_hit_y     = 6'(y);
    tick();
    bus.i_hit_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.i_vga_buzy = 1'b0;
    repeat (n) tick();
    bus.i_vga_buzy = 1'b1;
  endtask

  // Caller raises i_state to 01 just before; ready must appear on the 46th
  // sample point (45 cycles after the edge is registered).
  task automatic wait_ready(input string tag);
    repeat (45) tick();
    check_eq({tag, "_early"}, 32'(bus.o_ready), 32'd0);
    tick();
    check_eq({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vga"},   32'(bus.o_vga_is_wall),   32'd0);
    check_eq({tag, "_qv"},    32'(bus.o_query_valid),   32'd0);
    check_eq({tag, "_qw"},    32'(bus.o_query_is_wall), 32'd0);
    check_eq({tag, "_full"},  32'(bus.o_hit_full),      32'd0);
    check_eq({tag, "_ready"}, 32'(bus.o_ready),         32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic border_exp;
    int   hx [5];
    int   hy [5];
    hx = '{20, 22, 23, 20, 22};
    hy = '{10, 10, 10, 11, 11};

    rst_n             = 1'b0;
    bus.i_state       = GAME_START;
    bus.i_vga_buzy    = 1'b1;
    bus.i_vga_x       = '0;
    bus.i_vga_y       = '0;
    bus.i_query_valid = 1'b0;
    bus.i_query_x     = '0;
    bus.i_query_y     = '0;
    bus.i_hit_valid   = 1'b0;
    bus.i_hit_x       = '0;
    bus.i_hit_y       = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    query(5, 5, 1'b1, "idle_q55");
    vga(0, 0, 1'b0, "idle_vga_empty");

    // Load with a mid-load query
    bus.i_state = GAME_PLAY;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 10) begin
        bus.i_query_valid = 1'b1;
        bus.i_query_x     = 6'd5;
        bus.i_query_y     = 6'd5;
      end
      if (k == 11) begin
        check_eq("load_q55_vld", 32'(bus.o_query_valid), 32'd1);
        check_eq("load_q55", 32'(bus.o_query_is_wall), 32'd1);
        bus.i_query_valid = 1'b0;
      end
    end
    check_eq("load1_early", 32'(bus.o_ready), 32'd0);
    tick();
    check_eq("load1_ready", 32'(bus.o_ready), 32'd1);

    query(0, 0, 1'b1, "q00");
    query(5, 5, 1'b0, "q55");
    query(21, 11, 1'b1, "q2111");
    query(24, 11, 1'b0, "q2411");
    query(41, 31, 1'b1, "q4131");
    vga(21, 11, 1'b1, "vga2111");
    vga(19, 10, 1'b0, "vga1910");
    vga(63, 43, 1'b1, "vga6343");
    vga(0, 43, 1'b1, "vga0043");

    // Clear held off by busy, then committed in blank
    push_hit(21, 11);
    check_eq("hit1_full", 32'(bus.o_hit_full), 32'd0);
    repeat (100) tick();
    query(21, 11, 1'b1, "busy_hold");
    bus.i_vga_buzy = 1'b0;
    query(21, 11, 1'b1, "same_cycle_old");
    bus.i_vga_buzy = 1'b1;
    query(21, 11, 1'b0, "cleared2111");

    // Five pushes into a 4-deep FIFO
    bus.i_hit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_hit_x = 6'(hx[i]);
      bus.i_hit_y = 6'(hy[i]);
      tick();
      check_eq($sformatf("fill%0d_full", i), 32'(bus.o_hit_full), 32'(i >= 3));
    end
    bus.i_hit_valid = 1'b0;
    bus.i_vga_buzy  = 1'b0;
    tick();
    check_eq("pop1_full", 32'(bus.o_hit_full), 32'd0);
    repeat (3) tick();
    bus.i_vga_buzy = 1'b1;
    for (int i = 0; i < 4; i++)
      query(hx[i], hy[i], 1'b0, $sformatf("drained%0d", i));
    query(22, 11, 1'b1, "dropped5th");
    query(21, 10, 1'b1, "untouched2110");

    // Out-of-range rows
    query(5, 50, 1'b1, "q_y50");
    vga(0, 50, 1'b0, "vga_y50");

    // Border clear
`ifdef WALL_MAP_SOLID_BORDER_EN
    border_exp = 1'b1;
`else
    border_exp = 1'b0;
`endif
    push_hit(0, 10);
    drain(1);
    query(0, 10, border_exp, "border0010");

    // Leave play: map retained, queries solid, pushes ignored
    bus.i_state = GAME_END;
    tick();
    tick();
    check_eq("end_ready", 32'(bus.o_ready), 32'd0);
    query(21, 11, 1'b1, "end_q_solid");
    vga(21, 11, 1'b0, "end_vga_retained");
    bus.i_hit_valid = 1'b1;
    repeat (4) tick();
    bus.i_hit_valid = 1'b0;
    check_eq("idle_push_ignored", 32'(bus.o_hit_full), 32'd0);

    // Re-enter play: reload restores cleared cells
    bus.i_state = GAME_PLAY;
    wait_ready("reload");
    query(21, 11, 1'b1, "reload2111");
    query(20, 10, 1'b1, "reload2010");
    query(0, 10, 1'b1, "reload0010");

    // Restart mid-load
    bus.i_state = GAME_START;
    tick();
    bus.i_state = GAME_PLAY;
    repeat (20) tick();
    bus.i_state = GAME_START;
    tick();
    bus.i_state = GAME_PLAY;
    wait_ready("restart");

    // Async reset mid-load
    bus.i_state = GAME_START;
    tick();
    bus.i_state = GAME_PLAY;
    repeat (10) tick();
    bus.i_query_valid = 1'b1;
    bus.i_query_x     = 6'd5;
    bus.i_query_y     = 6'd5;
    bus.i_vga_x       = 6'd0;
    bus.i_vga_y       = 6'd0;
    tick();
    check_eq("preRst_qv",  32'(bus.o_query_valid),   32'd1);
    check_eq("preRst_qw",  32'(bus.o_query_is_wall), 32'd1);
    check_eq("preRst_vga", 32'(bus.o_vga_is_wall),   32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_rst");
    bus.i_query_valid = 1'b0;
    bus.i_state       = GAME_START;
    tick();
    rst_n = 1'b1;
    vga(0, 0, 1'b0, "post_rst_map_empty");
    check_eq("post_rst_ready", 32'(bus.o_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
